nco_phase_gen: RTL and testbench
================================

Name: nco_phase_gen

Overview:
- Numerically controlled phase generator directly upstream of the CORDIC sin/cos stage.
- Accumulates a programmable frequency control word (FCW) and adds a programmable phase offset.
- Wraps the result into [-pi, pi) and emits one angle per enabled cycle with a valid strobe.
- The angle format matches the CORDIC input: signed two's complement radians, 3 integer bits including sign, C_ANGLE_WIDTH-3 fraction bits.

Parameters:
C_ANGLE_WIDTH, 16, width of FCW, offset, accumulator and output angle. Must be 8 or more.
C_PI, round(pi*2**(C_ANGLE_WIDTH-3)), integer encoding of pi; 25736 at the default width.

Ports:
I_clk  input  1  clock; all logic on its rising edge.
I_rst  input  1  synchronous, active-high reset.
I_fcw  input  C_ANGLE_WIDTH  signed phase increment per enabled sample.
I_fcw_v  input  1  load strobe for I_fcw.
I_ofs  input  C_ANGLE_WIDTH  signed phase offset.
I_ofs_v  input  1  load strobe for I_ofs.
I_sync  input  1  phase-zero request; clears the accumulator.
I_en  input  1  sample enable; one output angle per high cycle.
O_angle  output  C_ANGLE_WIDTH  signed wrapped angle in [-C_PI, C_PI-1].
O_angle_v  output  1  O_angle valid strobe.

Behaviour:
- Reset (I_rst=1 at a clock edge) sets these registers to 0:
  - accumulator S_acc, FCW register S_fcw, offset register S_ofs
  - stage-1 phase and valid
  - O_angle and O_angle_v
- Reset overrides all other inputs in that cycle. Reset mid-stream discards both in-flight samples: O_angle_v=0 on the following two cycles unless new I_en arrives.
- Saturation on load:
  - I_fcw_v=1: S_fcw <= clamp(I_fcw, -(C_PI-1), C_PI-1).
  - I_ofs_v=1: S_ofs <= clamp(I_ofs, -(C_PI-1), C_PI-1).
  - The new value is used from the next cycle. A load in the same cycle as I_en uses the old register value for that sample.
- wrap(x): computed at C_ANGLE_WIDTH+1 bits (no intermediate overflow is possible).
  - x >= C_PI gives x - 2*C_PI.
  - x < -C_PI gives x + 2*C_PI.
  - Otherwise x unchanged.
  - Result truncated to C_ANGLE_WIDTH. +pi exactly maps to -pi; -pi is kept.
- Phase base:
  - base = 0 if I_sync=1, else S_acc.
- Stage 1, on every non-reset cycle:
  - S_ph1 <= wrap(base + S_ofs).
  - S_v1 <= I_en.
  - Accumulator update:
    - If I_en=1: S_acc <= wrap(base + S_fcw).
    - Else if I_sync=1: S_acc <= 0.
    - Else S_acc holds.
- Stage 2:
  - O_angle_v <= S_v1.
  - O_angle <= S_ph1 when S_v1=1; otherwise O_angle holds its last value.
- Latency: the sample enabled at cycle n appears at cycle n+2. Throughput is one sample per cycle; no backpressure.
- The first sample after reset or sync is exactly the offset value.
- Simultaneous events:
  - I_sync with I_en: the emitted sample is phase 0 (plus offset) and the accumulator advances from 0.
  - I_sync with I_fcw_v: the clear applies and the new FCW takes effect next cycle.
- FCW=0 gives a constant output. A negative FCW runs the phase backwards and wraps at -pi to the top of the range.

Test Plan:
1. Reset, load FCW=12868, I_en held high. O_angle_v rises 2 cycles after I_en. O_angle sequence: 0, 12868, -25736, -12868, 0, 12868. This covers wrap on +pi exactly.
2. Reset, load FCW=-12868, I_en high. Sequence: 0, -12868, -25736, 12868, 0. This covers -pi kept and wrap below -pi.
3. Load FCW=1000 and OFS=25000, I_en high. Sequence: 25000, -25472, -24472. The accumulator itself stays unwrapped: 0, 1000, 2000.
4. Load FCW=30000, then read back via the sequence. The FCW is saturated to 25735, giving: 0, 25735, -2, 25733. Repeat with I_fcw=-30000, giving: 0, -25735, 2.
5. FCW=100 with I_en pattern 1,1,0,0,1. O_angle_v pattern, delayed by 2: 1,1,0,0,1. Angles 0, 100, 200, with O_angle holding 100 during the gap.
6. Run FCW=100 for 5 samples, then pulse I_sync with I_en=1; next outputs 0, 100. Then assert I_rst mid-stream: O_angle=0 and O_angle_v=0 the next cycle. After release, S_fcw=0, so the output stays 0.

Source files
------------

// File: rtl/nco_phase_gen.sv
// Phase generator feeding the CORDIC stage: accumulates a saturated FCW, adds an
// offset, wraps into [-pi, pi) and emits one angle per enabled cycle, two cycles later.
module nco_phase_gen #(
    parameter int C_ANGLE_WIDTH = 16,
    parameter int C_PI          = $rtoi(3.141592653589793 * (2.0 ** (C_ANGLE_WIDTH - 3)) + 0.5)
) (
    input  logic                            I_clk,
    input  logic                            I_rst,
    input  logic signed [C_ANGLE_WIDTH-1:0] I_fcw,
    input  logic                            I_fcw_v,
    input  logic signed [C_ANGLE_WIDTH-1:0] I_ofs,
    input  logic                            I_ofs_v,
    input  logic                            I_sync,
    input  logic                            I_en,
    output logic signed [C_ANGLE_WIDTH-1:0] O_angle,
    output logic                            O_angle_v
);

    localparam int W = C_ANGLE_WIDTH;
    localparam logic signed [W:0]   PI_X     = (W+1)'(C_PI);
    localparam logic signed [W:0]   TWO_PI_X = (W+1)'(2 * C_PI);
    localparam logic signed [W-1:0] LIM_POS  = W'(C_PI - 1);
    localparam logic signed [W-1:0] LIM_NEG  = W'(-(C_PI - 1));

    // One extra bit holds the sum of two in-range angles without overflow.
    function automatic logic signed [W-1:0] wrap(input logic signed [W:0] x);
        logic signed [W:0] r;
        if (x >= PI_X) begin
            r = x - TWO_PI_X;
        end else if (x < -PI_X) begin
            r = x + TWO_PI_X;
        end else begin
            r = x;
        end
        return r[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] clamp(input logic signed [W-1:0] x);
        logic signed [W-1:0] r;
        if (x > LIM_POS) begin
            r = LIM_POS;
        end else if (x < LIM_NEG) begin
            r = LIM_NEG;
        end else begin
            r = x;
        end
        return r;
    endfunction

    logic signed [W-1:0] acc_q, acc_d;
    logic signed [W-1:0] fcw_q, fcw_d;
    logic signed [W-1:0] ofs_q, ofs_d;
    logic signed [W-1:0] ph1_q, ph1_d;
    logic                v1_q, v1_d;
    logic signed [W-1:0] angle_q, angle_d;
    logic                angle_v_q, angle_v_d;
    logic signed [W-1:0] base;

    always_comb begin
        base      = I_sync ? '0 : acc_q;
        ph1_d     = wrap({base[W-1], base} + {ofs_q[W-1], ofs_q});
        v1_d      = I_en;
        acc_d     = acc_q;
        if (I_en) begin
            acc_d = wrap({base[W-1], base} + {fcw_q[W-1], fcw_q});
        end else if (I_sync) begin
            acc_d = '0;
        end
        // Loads land next cycle, so a sample enabled now still sees the old values.
        fcw_d     = I_fcw_v ? clamp(I_fcw) : fcw_q;
        ofs_d     = I_ofs_v ? clamp(I_ofs) : ofs_q;
        angle_d   = v1_q ? ph1_q : angle_q;
        angle_v_d = v1_q;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            acc_q     <= '0;
            fcw_q     <= '0;
            ofs_q     <= '0;
            ph1_q     <= '0;
            v1_q      <= 1'b0;
            angle_q   <= '0;
            angle_v_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            fcw_q     <= fcw_d;
            ofs_q     <= ofs_d;
            ph1_q     <= ph1_d;
            v1_q      <= v1_d;
            angle_q   <= angle_d;
            angle_v_q <= angle_v_d;
        end
    end

    assign O_angle   = angle_q;
    assign O_angle_v = angle_v_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Bench for nco_phase_gen: directed angle sequences plus a randomized run against
// a modular-arithmetic reference, all scored through an expected-angle queue.
module tb_nco_phase_gen;

    localparam int W      = 16;
    localparam int PI     = 25736;
    localparam int TWO_PI = 2 * PI;

    logic                I_clk = 1'b0;
    logic                I_rst;
    logic signed [W-1:0] I_fcw;
    logic                I_fcw_v;
    logic signed [W-1:0] I_ofs;
    logic                I_ofs_v;
    logic                I_sync;
    logic                I_en;
    logic signed [W-1:0] O_angle;
    logic                O_angle_v;

    nco_phase_gen #(.C_ANGLE_WIDTH(W)) dut (
        .I_clk    (I_clk),
        .I_rst    (I_rst),
        .I_fcw    (I_fcw),
        .I_fcw_v  (I_fcw_v),
        .I_ofs    (I_ofs),
        .I_ofs_v  (I_ofs_v),
        .I_sync   (I_sync),
        .I_en     (I_en),
        .O_angle  (O_angle),
        .O_angle_v(O_angle_v)
    );

    always #5 I_clk = ~I_clk;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int last_angle = 0;
    bit started = 1'b0;

    // reference state
    int acc_m = 0;
    int fcw_m = 0;
    int ofs_m = 0;
    logic v1_m = 1'b0;
    logic v2_m = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int wrap_m(input int x);
        int m;
        m = (x + PI) % TWO_PI;
        if (m < 0) m += TWO_PI;
        return m - PI;
    endfunction

    function automatic int clamp_m(input int x);
        if (x > PI - 1) return PI - 1;
        if (x < -(PI - 1)) return -(PI - 1);
        return x;
    endfunction

    // expected valid: enable delayed by two cycles, cleared by reset
    always @(posedge I_clk) begin
        if (I_rst) begin
            v1_m <= 1'b0;
            v2_m <= 1'b0;
        end else begin
            v1_m <= I_en;
            v2_m <= v1_m;
        end
    end

    always @(negedge I_clk) begin
        if (started) begin
            check("angle_v", int'(O_angle_v), int'(v2_m));
            if (O_angle_v) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("angle", int'(O_angle), e);
                    last_angle = e;
                end
            end else begin
                check("angle_hold", int'(O_angle), last_angle);
            end
        end
    end

    // One clock of stimulus. When use_exp is set the directed value is scored,
    // otherwise the reference model's prediction is.
    task automatic step(input logic en, input logic sync,
                        input logic fcw_v, input int fcw,
                        input logic ofs_v, input int ofs,
                        input bit use_exp, input int exp);
        int base;
        I_en    = en;
        I_sync  = sync;
        I_fcw_v = fcw_v;
        I_fcw   = W'(fcw);
        I_ofs_v = ofs_v;
        I_ofs   = W'(ofs);
        base = sync ? 0 : acc_m;
        if (en) begin
            exp_q.push_back(use_exp ? exp : wrap_m(base + ofs_m));
            acc_m = wrap_m(base + fcw_m);
        end else if (sync) begin
            acc_m = 0;
        end
        if (fcw_v) fcw_m = clamp_m(fcw);
        if (ofs_v) ofs_m = clamp_m(ofs);
        @(posedge I_clk);
        #1;
        I_en    = 1'b0;
        I_sync  = 1'b0;
        I_fcw_v = 1'b0;
        I_ofs_v = 1'b0;
    endtask

    task automatic en_exp(input int exp);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic load_fcw(input int v);
        step(1'b0, 1'b0, 1'b1, v, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic load_ofs(input int v);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, v, 1'b0, 0);
    endtask

    task automatic do_reset();
        I_rst = 1'b1;
        I_en  = 1'b0;
        @(posedge I_clk);
        #1;
        exp_q.delete();
        last_angle = 0;
        acc_m = 0;
        fcw_m = 0;
        ofs_m = 0;
        I_rst = 1'b0;
    endtask

    initial begin
        int seq1[6];
        int seq2[5];
        I_rst = 1'b1; I_en = 1'b0; I_sync = 1'b0;
        I_fcw = '0; I_fcw_v = 1'b0; I_ofs = '0; I_ofs_v = 1'b0;
        repeat (2) @(posedge I_clk);
        #1;
        I_rst = 1'b0;
        check("rst_angle", int'(O_angle), 0);
        check("rst_angle_v", int'(O_angle_v), 0);
        started = 1'b1;

        // +pi wraps to -pi
        seq1 = '{0, 12868, -25736, -12868, 0, 12868};
        load_fcw(12868);
        foreach (seq1[i]) en_exp(seq1[i]);
        idle(3);

        // -pi kept, below -pi wraps up
        do_reset();
        seq2 = '{0, -12868, -25736, 12868, 0};
        load_fcw(-12868);
        foreach (seq2[i]) en_exp(seq2[i]);
        idle(3);

        // offset added after the accumulator
        do_reset();
        load_fcw(1000);
        load_ofs(25000);
        en_exp(25000); en_exp(-25472); en_exp(-24472);
        idle(3);

        // FCW saturation both ways
        do_reset();
        load_fcw(30000);
        en_exp(0); en_exp(25735); en_exp(-2); en_exp(25733);
        idle(3);
        do_reset();
        load_fcw(-30000);
        en_exp(0); en_exp(-25735); en_exp(2);
        idle(3);

        // gaps in enable hold the last angle
        do_reset();
        load_fcw(100);
        en_exp(0); en_exp(100); idle(2); en_exp(200);
        idle(3);

        // sync clears phase, then mid-stream reset drops in-flight samples
        do_reset();
        load_fcw(100);
        for (int i = 0; i < 5; i++) en_exp(i * 100);
        step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 0);
        en_exp(100);
        en_exp(200);
        do_reset();
        check("mid_rst_angle", int'(O_angle), 0);
        check("mid_rst_angle_v", int'(O_angle_v), 0);
        en_exp(0); en_exp(0); en_exp(0);
        idle(3);

        // load in the same cycle as enable uses the old FCW
        do_reset();
        load_fcw(500);
        step(1'b1, 1'b0, 1'b1, 700, 1'b0, 0, 1'b1, 0);
        en_exp(500);
        en_exp(1200);
        idle(3);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic signed [W-1:0] rf, ro;
            rf = W'($urandom_range(0, 65535));
            ro = W'($urandom_range(0, 65535));
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 15) == 0), int'(rf),
                 ($urandom_range(0, 15) == 0), int'(ro), 1'b0, 0);
        end
        idle(4);

        check("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
